// File: rtl/xadac_if.sv
// Handshake bundle for one xadac link: decode and execute channels, each a request
// (valid/ready + id/data) and a response (valid/ready + id/data).
interface xadac_if #(
  parameter int unsigned IdW   = 4,
  parameter int unsigned DataW = 32
) ();
  logic             dec_req_valid;
  logic             dec_req_ready;
  logic [IdW-1:0]   dec_req_id;
  logic [DataW-1:0] dec_req_data;
  logic             dec_rsp_valid;
  logic             dec_rsp_ready;
  logic [IdW-1:0]   dec_rsp_id;
  logic [DataW-1:0] dec_rsp_data;

  logic             exe_req_valid;
  logic             exe_req_ready;
  logic [IdW-1:0]   exe_req_id;
  logic [DataW-1:0] exe_req_data;
  logic             exe_rsp_valid;
  logic             exe_rsp_ready;
  logic [IdW-1:0]   exe_rsp_id;
  logic [DataW-1:0] exe_rsp_data;

  modport mst (
    output dec_req_valid, dec_req_id, dec_req_data, dec_rsp_ready,
    output exe_req_valid, exe_req_id, exe_req_data, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_data,
    input  exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_data
  );

  modport slv (
    input  dec_req_valid, dec_req_id, dec_req_data, dec_rsp_ready,
    input  exe_req_valid, exe_req_id, exe_req_data, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_data,
    output exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_data
  );
endinterface

// File: rtl/xadac_arb.sv
// Shares one xadac slave between NumMst masters: round-robin request arbitration per
// channel, with an order FIFO steering each response back to its issuer.
module xadac_arb #(
  parameter int unsigned NumMst = 2,
  parameter int unsigned MaxOut = 4,
  parameter int unsigned IdW    = 4,
  parameter int unsigned DataW  = 32
) (
  input  logic  clk,
  input  logic  rstn,
  xadac_if.slv  mst [NumMst],
  xadac_if.mst  slv,
  output logic  err
);
  localparam int unsigned IdxW  = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned PtrW  = (MaxOut > 1) ? $clog2(MaxOut) : 1;
  localparam int unsigned CntW  = $clog2(MaxOut + 1);
  localparam int unsigned PlW   = IdW + DataW;
  localparam int unsigned NumCh = 2;

  // Channel 0 is decode, channel 1 is execute.
  logic [NumCh-1:0][NumMst-1:0]          m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
  logic [NumCh-1:0][NumMst-1:0][PlW-1:0] m_req_pl;
  logic [NumCh-1:0]                      s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [NumCh-1:0][PlW-1:0]             s_req_pl;
  logic [NumCh-1:0]                      stray;
  logic                                  err_q;

  for (genvar g = 0; g < NumMst; g++) begin : g_mst
    assign m_req_valid[0][g]  = mst[g].dec_req_valid;
    assign m_req_pl[0][g]     = {mst[g].dec_req_id, mst[g].dec_req_data};
    assign m_rsp_ready[0][g]  = mst[g].dec_rsp_ready;
    assign mst[g].dec_req_ready = m_req_ready[0][g];
    assign mst[g].dec_rsp_valid = m_rsp_valid[0][g];
    assign mst[g].dec_rsp_id    = slv.dec_rsp_id;
    assign mst[g].dec_rsp_data  = slv.dec_rsp_data;

    assign m_req_valid[1][g]  = mst[g].exe_req_valid;
    assign m_req_pl[1][g]     = {mst[g].exe_req_id, mst[g].exe_req_data};
    assign m_rsp_ready[1][g]  = mst[g].exe_rsp_ready;
    assign mst[g].exe_req_ready = m_req_ready[1][g];
    assign mst[g].exe_rsp_valid = m_rsp_valid[1][g];
    assign mst[g].exe_rsp_id    = slv.exe_rsp_id;
    assign mst[g].exe_rsp_data  = slv.exe_rsp_data;
  end

  assign slv.dec_req_valid                   = s_req_valid[0];
  assign {slv.dec_req_id, slv.dec_req_data} = s_req_pl[0];
  assign slv.dec_rsp_ready                   = s_rsp_ready[0];
  assign s_req_ready[0]                      = slv.dec_req_ready;
  assign s_rsp_valid[0]                      = slv.dec_rsp_valid;

  assign slv.exe_req_valid                   = s_req_valid[1];
  assign {slv.exe_req_id, slv.exe_req_data} = s_req_pl[1];
  assign slv.exe_rsp_ready                   = s_rsp_ready[1];
  assign s_req_ready[1]                      = slv.exe_req_ready;
  assign s_rsp_valid[1]                      = slv.exe_rsp_valid;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt_idx, tgt_idx, cand;
    logic            lock_q, lock_d, gnt_vld, tgt_vld, byp, req_hs, rsp_hs, push, pop;
    logic [IdxW-1:0] fifo_q [MaxOut];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [NumMst-1:0] req_rdy, rsp_vld;
    logic            srv, srr, stray_l;

    // Grant looks only at valids and state so ready never loops back into it.
    always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (lock_q) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_idx_q;
      end else if (cnt_q != CntW'(MaxOut)) begin
        for (int unsigned k = 0; k < NumMst; k++) begin
          cand = IdxW'((32'(rr_q) + k) % NumMst);
          if (!gnt_vld && m_req_valid[c][cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end

    always_comb begin
      srv     = 1'b0;
      srr     = 1'b0;
      req_rdy = '0;
      rsp_vld = '0;
      tgt_vld = 1'b0;
      tgt_idx = '0;
      byp     = 1'b0;
      stray_l = 1'b0;
      if (rstn) begin
        if (gnt_vld) begin
          srv              = m_req_valid[c][gnt_idx];
          req_rdy[gnt_idx] = s_req_ready[c];
        end
        // Empty FIFO falls back to the live grant so same-cycle slaves work.
        if (cnt_q != '0) begin
          tgt_vld = 1'b1;
          tgt_idx = fifo_q[rptr_q];
        end else if (gnt_vld) begin
          tgt_vld = 1'b1;
          tgt_idx = gnt_idx;
          byp     = 1'b1;
        end
        if (tgt_vld) begin
          rsp_vld[tgt_idx] = s_rsp_valid[c];
          srr              = m_rsp_ready[c][tgt_idx];
        end else begin
          srr     = 1'b1;
          stray_l = s_rsp_valid[c];
        end
      end
      req_hs = srv & s_req_ready[c];
      rsp_hs = tgt_vld & s_rsp_valid[c] & srr;
      push   = req_hs & ~(byp & rsp_hs);
      pop    = rsp_hs & ~byp;
    end

    assign m_req_ready[c] = req_rdy;
    assign m_rsp_valid[c] = rsp_vld;
    assign s_req_valid[c] = srv;
    assign s_req_pl[c]    = m_req_pl[c][gnt_idx];
    assign s_rsp_ready[c] = srr;
    assign stray[c]       = stray_l;

    always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      wptr_d     = wptr_q + PtrW'(push);
      rptr_d     = rptr_q + PtrW'(pop);
      cnt_d      = cnt_q;
      if (push && !pop) cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);
      if (req_hs) begin
        rr_d   = (gnt_idx == IdxW'(NumMst - 1)) ? '0 : gnt_idx + IdxW'(1);
        lock_d = 1'b0;
      end else if (srv) begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
        wptr_q     <= '0;
        rptr_q     <= '0;
        cnt_q      <= '0;
      end else begin
        rr_q       <= rr_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
        wptr_q     <= wptr_d;
        rptr_q     <= rptr_d;
        cnt_q      <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rstn && push) fifo_q[wptr_q] <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else if (|stray) err_q <= 1'b1;
  end

  assign err = err_q;
endmodule

// File: tb/tb_xadac_arb.sv
// Directed bench for xadac_arb: queued master requests, a configurable slave model and a
// scoreboard checking slave-side grant order and per-master response steering.
module tb_xadac_arb;
  localparam int unsigned NumMst = 2;
  localparam int unsigned MaxOut = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic err;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  xadac_if mst_if [NumMst] ();
  xadac_if slv_if ();

  xadac_arb #(.NumMst(NumMst), .MaxOut(MaxOut)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mst  (mst_if),
    .slv  (slv_if),
    .err  (err)
  );

  // Index order: [channel][master], channel 0 = dec, 1 = exe; ids carry master in bit 3.
  logic       m_vld [2][2];
  logic [3:0] m_id  [2][2];
  logic       m_rdy [2][2];
  logic       m_rvld[2][2];
  logic [3:0] m_rid [2][2];
  logic       s_vld [2];
  logic [3:0] s_id  [2];
  logic       s_rdy [2];
  logic       s_rvld[2];
  logic [3:0] s_rid [2];
  logic       s_rrdy[2];
  int         smode [2];
  int         lat   [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign mst_if[g].dec_req_valid = m_vld[0][g];
    assign mst_if[g].dec_req_id    = m_id[0][g];
    assign mst_if[g].dec_req_data  = 32'(m_id[0][g]);
    assign mst_if[g].dec_rsp_ready = 1'b1;
    assign m_rdy[0][g]  = mst_if[g].dec_req_ready;
    assign m_rvld[0][g] = mst_if[g].dec_rsp_valid;
    assign m_rid[0][g]  = mst_if[g].dec_rsp_id;
    assign mst_if[g].exe_req_valid = m_vld[1][g];
    assign mst_if[g].exe_req_id    = m_id[1][g];
    assign mst_if[g].exe_req_data  = 32'(m_id[1][g]);
    assign mst_if[g].exe_rsp_ready = 1'b1;
    assign m_rdy[1][g]  = mst_if[g].exe_req_ready;
    assign m_rvld[1][g] = mst_if[g].exe_rsp_valid;
    assign m_rid[1][g]  = mst_if[g].exe_rsp_id;
  end

  assign s_vld[0] = slv_if.dec_req_valid;
  assign s_id[0]  = slv_if.dec_req_id;
  assign s_rrdy[0] = slv_if.dec_rsp_ready;
  assign slv_if.dec_req_ready = s_rdy[0];
  assign slv_if.dec_rsp_valid = s_rvld[0];
  assign slv_if.dec_rsp_id    = s_rid[0];
  assign slv_if.dec_rsp_data  = '0;
  assign s_vld[1] = slv_if.exe_req_valid;
  assign s_id[1]  = slv_if.exe_req_id;
  assign s_rrdy[1] = slv_if.exe_rsp_ready;
  assign slv_if.exe_req_ready = s_rdy[1];
  assign slv_if.exe_rsp_valid = s_rvld[1];
  assign slv_if.exe_rsp_id    = s_rid[1];
  assign slv_if.exe_rsp_data  = '0;

  logic [3:0] mq  [4][$];   // pending requests per (ch*2+m)
  logic [3:0] er  [4][$];   // expected responses per (ch*2+m)
  logic [3:0] eg  [2][$];   // expected slave-side request order
  int         hcyc[2][$];   // cycles of slave-side request handshakes
  logic [3:0] pq_id [2][$];
  int         pq_due[2][$];
  logic       p_vld[2];
  logic [3:0] p_id [2];
  logic       mhs_s[2][2];
  logic       hs_s [2];
  logic       rhs_s[2];
  logic [3:0] hid_s[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave model: 0 = same-cycle echo, 1 = pipelined with lat[] cycles, 2 = stray response.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      s_rvld[c] = 1'b0;
      s_rid[c]  = '0;
      case (smode[c])
        0: begin s_rvld[c] = s_vld[c] & s_rdy[c]; s_rid[c] = s_id[c]; end
        1: begin s_rvld[c] = p_vld[c]; s_rid[c] = p_id[c]; end
        default: begin s_rvld[c] = 1'b1; s_rid[c] = '0; end
      endcase
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      hs_s[c]  <= s_vld[c] && s_rdy[c];
      rhs_s[c] <= s_rvld[c] && s_rrdy[c];
      hid_s[c] <= s_id[c];
      for (int m = 0; m < 2; m++) mhs_s[c][m] <= m_vld[c][m] && m_rdy[c][m];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (!rstn) begin
        pq_id[c].delete();
        pq_due[c].delete();
        p_vld[c] <= 1'b0;
        p_id[c]  <= '0;
      end else begin
        if (smode[c] == 1 && rhs_s[c] && pq_id[c].size() > 0) begin
          void'(pq_id[c].pop_front());
          void'(pq_due[c].pop_front());
        end
        if (smode[c] == 1 && hs_s[c]) begin
          pq_id[c].push_back(hid_s[c]);
          pq_due[c].push_back(cyc + lat[c]);
        end
        p_vld[c] <= pq_id[c].size() > 0 && pq_due[c][0] <= cyc + 1;
        p_id[c]  <= (pq_id[c].size() > 0) ? pq_id[c][0] : 4'd0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!rstn) begin
          mq[c*2+m].delete();
          m_vld[c][m] <= 1'b0;
          m_id[c][m]  <= '0;
        end else begin
          if (mhs_s[c][m] && mq[c*2+m].size() > 0) void'(mq[c*2+m].pop_front());
          m_vld[c][m] <= mq[c*2+m].size() > 0;
          m_id[c][m]  <= (mq[c*2+m].size() > 0) ? mq[c*2+m][0] : 4'd0;
        end
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn) begin
      for (int c = 0; c < 2; c++) begin
        if (s_vld[c] && s_rdy[c]) begin
          hcyc[c].push_back(cyc);
          if (eg[c].size() == 0) chk($sformatf("req_unexp_ch%0d_id%0d", c, s_id[c]), 1, 0);
          else chk($sformatf("req_order_ch%0d", c), s_id[c], eg[c].pop_front());
        end
        for (int m = 0; m < 2; m++) begin
          if (m_rvld[c][m]) begin
            if (er[c*2+m].size() == 0)
              chk($sformatf("rsp_unexp_ch%0d_m%0d_id%0d", c, m, m_rid[c][m]), 1, 0);
            else chk($sformatf("rsp_route_ch%0d_m%0d", c, m), m_rid[c][m], er[c*2+m].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input int m, input logic [3:0] id);
    mq[c*2+m].push_back(id);
    er[c*2+m].push_back(id);
  endtask

  function automatic int busy();
    int n = 0;
    for (int k = 0; k < 4; k++) n += mq[k].size() + er[k].size();
    for (int c = 0; c < 2; c++) n += eg[c].size();
    return n;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while (busy() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, busy(), 0);
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) er[k].delete();
    for (int c = 0; c < 2; c++) eg[c].delete();
    tick();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst_req_valid_ch%0d", c), s_vld[c], 0);
      chk($sformatf("rst_rsp_ready_ch%0d", c), s_rrdy[c], 0);
    end
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) hcyc[c].delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    smode[0] = 0; smode[1] = 0;
    lat[0] = 2;   lat[1] = 2;
    s_rdy[0] = 1'b1; s_rdy[1] = 1'b1;
    do_reset();
    chk("rst_err", err, 0);

    // Single master, same-cycle slave: three back-to-back handshakes.
    tick();
    send(1, 0, 4'd1); send(1, 0, 4'd2); send(1, 0, 4'd3);
    eg[1].push_back(4'd1); eg[1].push_back(4'd2); eg[1].push_back(4'd3);
    wait_idle("t1", 40);
    chk("t1_hs_count", hcyc[1].size(), 3);
    if (hcyc[1].size() == 3) chk("t1_hs_span", hcyc[1][2] - hcyc[1][0], 2);
    chk("t1_err", err, 0);

    // Contention: strict alternation 0,1,0,1,0,1.
    do_reset();
    tick();
    send(1, 0, 4'd1); send(1, 0, 4'd2); send(1, 0, 4'd3);
    send(1, 1, 4'd9); send(1, 1, 4'd10); send(1, 1, 4'd11);
    eg[1].push_back(4'd1); eg[1].push_back(4'd9);  eg[1].push_back(4'd2);
    eg[1].push_back(4'd10); eg[1].push_back(4'd3); eg[1].push_back(4'd11);
    wait_idle("t2", 40);
    chk("t2_hs_count", hcyc[1].size(), 6);
    if (hcyc[1].size() == 6) chk("t2_hs_span", hcyc[1][5] - hcyc[1][0], 5);

    // Backpressure lock: mst1 granted first and held while mst0 waits.
    do_reset();
    s_rdy[1] = 1'b0;
    tick();
    send(1, 1, 4'd9);
    eg[1].push_back(4'd9); eg[1].push_back(4'd1);
    tick();
    send(1, 0, 4'd1);
    tick();
    chk("t3_lock_id_a", s_id[1], 9);
    chk("t3_lock_vld_a", s_vld[1], 1);
    chk("t3_m0_not_ready", m_rdy[1][0], 0);
    tick();
    chk("t3_lock_id_b", s_id[1], 9);
    tick();
    s_rdy[1] = 1'b1;
    wait_idle("t3", 40);
    chk("t3_hs_count", hcyc[1].size(), 2);

    // Pipelined slave: fifth request waits for the first response to pop.
    do_reset();
    smode[1] = 1;
    lat[1] = 5;
    tick();
    send(1, 0, 4'd1); send(1, 0, 4'd2); send(1, 0, 4'd3);
    send(1, 1, 4'd9); send(1, 1, 4'd10);
    eg[1].push_back(4'd1); eg[1].push_back(4'd9); eg[1].push_back(4'd2);
    eg[1].push_back(4'd10); eg[1].push_back(4'd3);
    wait_idle("t4", 80);
    chk("t4_hs_count", hcyc[1].size(), 5);
    if (hcyc[1].size() == 5) chk("t4_fifth_delay", hcyc[1][4] - hcyc[1][0], 6);
    smode[1] = 0;

    // Stray response: dropped, no master sees it, sticky error.
    do_reset();
    tick();
    smode[1] = 2;
    #1;
    chk("t5_stray_ready", s_rrdy[1], 1);
    chk("t5_m0_rsp_valid", m_rvld[1][0], 0);
    chk("t5_m1_rsp_valid", m_rvld[1][1], 0);
    chk("t5_err_before_edge", err, 0);
    tick();
    chk("t5_err_set", err, 1);
    smode[1] = 0;
    tick();
    tick();
    chk("t5_err_sticky", err, 1);

    // Reset mid-operation with two dec requests outstanding.
    smode[0] = 1;
    lat[0] = 10;
    tick();
    send(0, 0, 4'd1); send(0, 0, 4'd2);
    eg[0].push_back(4'd1); eg[0].push_back(4'd2);
    for (int n = 0; n < 20 && hcyc[0].size() < 2; n++) tick();
    chk("t6_outstanding", hcyc[0].size(), 2);
    do_reset();
    chk("t6_err_cleared", err, 0);
    smode[0] = 0;
    tick();
    send(0, 0, 4'd3); send(0, 1, 4'd10);
    eg[0].push_back(4'd3); eg[0].push_back(4'd10);
    wait_idle("t6a", 40);
    tick();
    send(0, 1, 4'd9);
    eg[0].push_back(4'd9);
    wait_idle("t6b", 40);
    chk("t6_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
